output_queue_scheduler: RTL and testbench

OUTPUT_QUEUE_SCHEDULER -- requirements
Module: output_queue_scheduler

---
 rtl/output_queue_scheduler.sv | 184 ++++++++++++++++++
 tb/tb_output_queue_scheduler.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/output_queue_scheduler.sv
// Output-port queue scheduler: strict priority or deficit round robin (DRR)
// selection of one of PRI_NUM queues, then a request/ack handshake with the
// read engine and a wait for end of packet.
// Optional feature: define SCHED_TIMEOUT_EN to add a WAIT_DONE watchdog that
// pulses timeout_err and returns to SELECT after TIMEOUT_CYCLES cycles.
module output_queue_scheduler #(
  parameter int unsigned PRI_NUM        = 8,
  parameter int unsigned LEN_WIDTH      = 12,
  parameter int unsigned TIMEOUT_CYCLES = 1023
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           sched_mode,
  input  logic [PRI_NUM-1:0]             q_nonempty,
  input  logic [PRI_NUM*LEN_WIDTH-1:0]   q_head_len,
  input  logic [PRI_NUM*LEN_WIDTH-1:0]   quantum,
  input  logic                           deq_ack,
  input  logic                           pkt_done,
  output logic                           deq_req,
  output logic [$clog2(PRI_NUM)-1:0]     deq_qid,
  output logic                           busy,
  output logic                           timeout_err
);

  localparam int unsigned QID_W = $clog2(PRI_NUM);
  localparam int unsigned DEF_W = LEN_WIDTH + 1;
  localparam int unsigned SUM_W = DEF_W + 1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SELECT    = 2'd1,
    GRANT     = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [QID_W-1:0]     r_rr_ptr;
  logic [QID_W-1:0]     w_rr_ptr_nxt;
  logic [QID_W-1:0]     w_rr_ptr_inc;
  logic [QID_W-1:0]     w_qid_nxt;
  logic [QID_W-1:0]     w_strict_qid;
  logic [DEF_W-1:0]     r_deficit [PRI_NUM];
  logic [LEN_WIDTH-1:0] w_len     [PRI_NUM];
  logic [LEN_WIDTH-1:0] w_quant   [PRI_NUM];
  logic [DEF_W-1:0]     w_def_cur;
  logic [DEF_W-1:0]     w_len_cur;
  logic [DEF_W-1:0]     w_quant_cur;
  logic [DEF_W-1:0]     w_def_add;
  logic [DEF_W-1:0]     w_def_wval;
  logic [SUM_W-1:0]     w_def_sum;
  logic                 w_def_we;
  logic                 w_wd_expire;

  // Unpack per-queue head lengths and quanta
  always_comb begin
    for (int i = 0; i < PRI_NUM; i++) begin
      w_len[i]   = q_head_len[i*LEN_WIDTH +: LEN_WIDTH];
      w_quant[i] = quantum[i*LEN_WIDTH +: LEN_WIDTH];
    end
  end

  // DRR operands for the queue under the round-robin pointer
  always_comb begin
    w_rr_ptr_inc = (r_rr_ptr == QID_W'(PRI_NUM - 1)) ? '0 : r_rr_ptr + QID_W'(1);
    w_def_cur    = r_deficit[r_rr_ptr];
    w_len_cur    = DEF_W'(w_len[r_rr_ptr]);
    w_quant_cur  = DEF_W'(w_quant[r_rr_ptr]);
    w_def_sum    = SUM_W'(w_def_cur) + SUM_W'(w_quant_cur);
    w_def_add    = w_def_sum[DEF_W] ? '1 : w_def_sum[DEF_W-1:0];
  end

  // Strict priority: highest-index nonempty queue wins
  always_comb begin
    w_strict_qid = '0;
    for (int i = 0; i < PRI_NUM; i++) begin
      if (q_nonempty[i]) w_strict_qid = QID_W'(i);
    end
  end

`ifdef SCHED_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] r_wdog;

  assign w_wd_expire = (r_state == WAIT_DONE) && (r_wdog == WD_W'(TIMEOUT_CYCLES - 1));

  // Watchdog counts consecutive WAIT_DONE cycles, clears on any exit
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wdog <= '0;
    end else if ((r_state == WAIT_DONE) && (w_state_nxt == WAIT_DONE)) begin
      r_wdog <= r_wdog + WD_W'(1);
    end else begin
      r_wdog <= '0;
    end
  end

  // Error pulse on expiry; a coincident pkt_done suppresses it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= w_wd_expire && !pkt_done;
    end
  end
`else
  // Watchdog compiled out: WAIT_DONE waits for pkt_done indefinitely
  assign w_wd_expire = 1'b0;
  assign timeout_err = 1'b0 & (TIMEOUT_CYCLES != 0);
`endif

  // Next-state, queue selection and DRR deficit update
  always_comb begin
    w_state_nxt  = r_state;
    w_qid_nxt    = deq_qid;
    w_rr_ptr_nxt = r_rr_ptr;
    w_def_we     = 1'b0;
    w_def_wval   = '0;
    case (r_state)
      IDLE: begin
        if (|q_nonempty) w_state_nxt = SELECT;
      end
      SELECT: begin
        if (!(|q_nonempty)) begin
          w_state_nxt = IDLE;
        end else if (!sched_mode) begin
          w_qid_nxt   = w_strict_qid;
          w_state_nxt = GRANT;
        end else if (!q_nonempty[r_rr_ptr]) begin
          w_def_we     = 1'b1;
          w_def_wval   = '0;
          w_rr_ptr_nxt = w_rr_ptr_inc;
        end else if ((w_quant_cur != '0) && (w_def_cur >= w_len_cur)) begin
          w_qid_nxt   = r_rr_ptr;
          w_def_we    = 1'b1;
          w_def_wval  = w_def_cur - w_len_cur;
          w_state_nxt = GRANT;
        end else begin
          w_def_we     = 1'b1;
          w_def_wval   = w_def_add;
          w_rr_ptr_nxt = w_rr_ptr_inc;
        end
      end
      GRANT: begin
        if (deq_ack) w_state_nxt = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (pkt_done) begin
          w_state_nxt = SELECT;
        end else if (w_wd_expire) begin
          w_state_nxt = SELECT;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State, pointer and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_rr_ptr <= '0;
      deq_req  <= 1'b0;
      deq_qid  <= '0;
      busy     <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_rr_ptr <= w_rr_ptr_nxt;
      deq_req  <= (w_state_nxt == GRANT);
      deq_qid  <= w_qid_nxt;
      busy     <= (w_state_nxt != IDLE);
    end
  end

  // Deficit counters, one entry written per SELECT cycle in DRR mode
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < PRI_NUM; i++) r_deficit[i] <= '0;
    end else if (w_def_we) begin
      r_deficit[r_rr_ptr] <= w_def_wval;
    end
  end

endmodule

// File: tb/tb_output_queue_scheduler.sv
// Randomized bench for output_queue_scheduler. Acts as queue manager and read
// engine; a transaction-level model predicts each grant and its latency.
module tb_output_queue_scheduler;

  localparam int N   = 8;
  localparam int LW  = 12;
  localparam int DMAX = 8191;

  logic            clk;
  logic            reset;
  logic            sched_mode;
  logic [N-1:0]    q_nonempty;
  logic [N*LW-1:0] q_head_len;
  logic [N*LW-1:0] quantum;
  logic            deq_ack;
  logic            pkt_done;
  logic            deq_req;
  logic [2:0]      deq_qid;
  logic            busy;
  logic            timeout_err;

  output_queue_scheduler #(.PRI_NUM(N), .LEN_WIDTH(LW), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset(reset), .sched_mode(sched_mode), .q_nonempty(q_nonempty),
    .q_head_len(q_head_len), .quantum(quantum), .deq_ack(deq_ack),
    .pkt_done(pkt_done), .deq_req(deq_req), .deq_qid(deq_qid), .busy(busy),
    .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // environment: packets per queue, head length, quantum
  int q_cnt   [N];
  int q_len   [N];
  int q_quant [N];
  // reference model state
  int m_def   [N];
  int m_rr;
  int seq[$];

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_env();
    for (int i = 0; i < N; i++) begin
      q_nonempty[i]          = (q_cnt[i] > 0);
      q_head_len[i*LW +: LW] = LW'(q_len[i]);
      quantum[i*LW +: LW]    = LW'(q_quant[i]);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_def[i] = 0;
    m_rr = 0;
  endtask

  function automatic bit servable(input bit drr);
    for (int i = 0; i < N; i++)
      if (q_cnt[i] > 0 && (!drr || q_quant[i] > 0)) return 1'b1;
    return 1'b0;
  endfunction

  // Next grant and number of non-granting DRR visits before it
  function automatic void model_pick(input bit drr, output int qid, output int steps);
    qid = -1;
    steps = 0;
    if (!drr) begin
      for (int i = 0; i < N; i++) if (q_cnt[i] > 0) qid = i;
    end else begin
      for (int g = 0; g < 4000 && qid < 0; g++) begin
        int p;
        p = m_rr;
        if (q_cnt[p] == 0) begin
          m_def[p] = 0;
          m_rr = (p + 1) % N;
          steps++;
        end else if (q_quant[p] > 0 && m_def[p] >= q_len[p]) begin
          m_def[p] -= q_len[p];
          qid = p;
        end else begin
          m_def[p] = (m_def[p] + q_quant[p] > DMAX) ? DMAX : m_def[p] + q_quant[p];
          m_rr = (p + 1) % N;
          steps++;
        end
      end
    end
  endfunction

  task automatic apply_reset();
    deq_ack = 1'b0;
    pkt_done = 1'b0;
    sched_mode = 1'b0;
    for (int i = 0; i < N; i++) begin
      q_cnt[i] = 0; q_len[i] = 0; q_quant[i] = 0;
    end
    drive_env();
    reset = 1'b1;
    tick();
    tick();
    chk("rst_req", int'(deq_req), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_qid", int'(deq_qid), 0);
    chk("rst_tmo", int'(timeout_err), 0);
    reset = 1'b0;
    model_reset();
    seq.delete();
  endtask

  // Serve up to n packets; returns with the DUT in WAIT_DONE after the last ack
  task automatic run_phase(input bit drr, input int n, input int ack_lo, input int ack_hi,
                           input int done_lo, input int done_hi, input bit rnd);
    int qid, steps, lat, ad, dd;
    sched_mode = drr;
    drive_env();
    for (int g = 0; g < n; g++) begin
      if (!servable(drr)) break;
      if (g > 0) pkt_done = 1'b1;
      model_pick(drr, qid, steps);
      lat = 0;
      do begin
        tick();
        pkt_done = 1'b0;
        lat++;
      end while (deq_req !== 1'b1 && lat < 5000);
      chk("grant_latency", lat, 2 + steps);
      if (deq_req !== 1'b1) return;
      chk("grant_qid", int'(deq_qid), qid);
      chk("grant_busy", int'(busy), 1);
      seq.push_back(int'(deq_qid));
      ad = $urandom_range(ack_hi, ack_lo);
      for (int k = 0; k < ad; k++) begin
        pkt_done = ($urandom_range(3, 0) == 0);
        tick();
        chk("req_hold", int'(deq_req), 1);
        chk("qid_hold", int'(deq_qid), qid);
      end
      pkt_done = 1'b0;
      deq_ack = 1'b1;
      tick();
      deq_ack = 1'b0;
      chk("req_drop", int'(deq_req), 0);
      q_cnt[qid]--;
      if (rnd) begin
        q_len[qid] = $urandom_range(4095, 1);
        if ($urandom_range(2, 0) == 0) begin
          int a;
          a = $urandom_range(N - 1, 0);
          if (q_cnt[a] < 6) q_cnt[a]++;
        end
      end
      drive_env();
      dd = $urandom_range(done_hi, done_lo);
      for (int k = 0; k < dd; k++) begin
        tick();
        chk("wait_no_req", int'(deq_req), 0);
      end
    end
  endtask

  // Final pkt_done with every queue empty: SELECT then back to IDLE
  task automatic finish_idle();
    pkt_done = 1'b1;
    tick();
    pkt_done = 1'b0;
    tick();
    chk("end_idle_busy", int'(busy), 0);
    chk("end_idle_req", int'(deq_req), 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int c0, c1, seen, n;
    int exp33 [6];
    reset = 1'b1;
    deq_ack = 1'b0;
    pkt_done = 1'b0;
    sched_mode = 1'b0;
    q_nonempty = '0;
    q_head_len = '0;
    quantum = '0;
    #3;
    chk("async_rst_busy", int'(busy), 0);
    chk("async_rst_req", int'(deq_req), 0);

    // strict order 7, then 2 until empty, then 0
    apply_reset();
    q_cnt[7] = 1; q_cnt[2] = 3; q_cnt[0] = 2;
    for (int i = 0; i < N; i++) q_len[i] = 100;
    run_phase(1'b0, 20, 0, 0, 2, 2, 1'b0);
    exp33 = '{7, 2, 2, 2, 0, 0};
    chk("strict_seq_len", seq.size(), 6);
    for (int i = 0; i < 6 && i < seq.size(); i++) chk("strict_seq", seq[i], exp33[i]);
    finish_idle();

    // ack withheld for 10 cycles
    apply_reset();
    q_cnt[4] = 1; q_len[4] = 64;
    run_phase(1'b0, 1, 10, 10, 1, 1, 1'b0);
    finish_idle();

    // DRR 2:1 with quanta 600/300 and equal 300-byte heads
    apply_reset();
    q_cnt[0] = 1000; q_cnt[1] = 1000;
    q_len[0] = 300; q_len[1] = 300;
    q_quant[0] = 600; q_quant[1] = 300;
    run_phase(1'b1, 30, 0, 1, 0, 2, 1'b0);
    c0 = 0; c1 = 0;
    foreach (seq[i]) begin
      if (seq[i] == 0) c0++;
      if (seq[i] == 1) c1++;
    end
    chk("drr_q0_grants", c0, 20);
    chk("drr_q1_grants", c1, 10);

    // all quanta zero: SELECT spins, no request ever
    apply_reset();
    q_cnt[0] = 1; q_len[0] = 10;
    sched_mode = 1'b1;
    drive_env();
    seen = 0;
    repeat (60) begin
      tick();
      if (deq_req === 1'b1) seen = 1;
    end
    chk("q0_zero_quantum_req", seen, 0);
    chk("q0_zero_quantum_busy", int'(busy), 1);

    // reset in WAIT_DONE for queue 3, DRR state must restart from zero
    apply_reset();
    q_cnt[3] = 4; q_len[3] = 250; q_quant[3] = 100;
    run_phase(1'b1, 1, 0, 0, 2, 2, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_req", int'(deq_req), 0);
    chk("mid_rst_qid", int'(deq_qid), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_tmo", int'(timeout_err), 0);
    tick();
    chk("mid_rst_hold_req", int'(deq_req), 0);
    reset = 1'b0;
    model_reset();
    run_phase(1'b1, 3, 0, 1, 0, 2, 1'b0);
    chk("q3_drained", q_cnt[3], 0);
    finish_idle();

    // random strict traffic
    apply_reset();
    for (int i = 0; i < N; i++) begin
      q_cnt[i] = $urandom_range(4, 0);
      q_len[i] = $urandom_range(4095, 1);
      q_quant[i] = $urandom_range(4095, 0);
    end
    run_phase(1'b0, 150, 0, 3, 0, 4, 1'b1);

    // random DRR traffic, some queues with zero quantum
    apply_reset();
    for (int i = 0; i < N; i++) begin
      q_cnt[i] = $urandom_range(4, 0);
      q_len[i] = $urandom_range(4095, 1);
      q_quant[i] = ($urandom_range(5, 0) == 0) ? 0 : $urandom_range(4095, 200);
    end
    q_cnt[6] = 3; q_quant[6] = 1500;
    run_phase(1'b1, 100, 0, 3, 0, 4, 1'b1);

`ifdef SCHED_TIMEOUT_EN
    // watchdog expiry after 16 WAIT_DONE cycles, then the next grant
    apply_reset();
    q_cnt[1] = 3; q_len[1] = 10;
    run_phase(1'b0, 1, 0, 0, 0, 0, 1'b0);
    n = 0;
    seen = 0;
    do begin
      tick();
      n++;
      if (busy !== 1'b1) seen = 1;
    end while (timeout_err !== 1'b1 && n < 100);
    chk("tmo_cycle", n, 16);
    tick();
    chk("tmo_single_pulse", int'(timeout_err), 0);
    chk("tmo_next_req", int'(deq_req), 1);
    chk("tmo_next_qid", int'(deq_qid), 1);
    chk("tmo_busy_kept", seen, 0);
    // pkt_done on the expiry cycle wins
    deq_ack = 1'b1;
    tick();
    deq_ack = 1'b0;
    repeat (15) tick();
    pkt_done = 1'b1;
    tick();
    pkt_done = 1'b0;
    chk("tmo_done_wins", int'(timeout_err), 0);
    tick();
    chk("tmo_done_wins_late", int'(timeout_err), 0);
    chk("tmo_done_next_req", int'(deq_req), 1);
`else
    n = 0;
    chk("no_wd_tmo", int'(timeout_err), n);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
